// File: rtl/fnd_display_driver.sv
// Four-digit common-anode seven-segment scanner for an 8-bit unsigned value.
// The value is latched once per scan frame and shown in decimal with optional leading-zero blanking.
module fnd_display_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_value,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_font
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [7:0]       BLANK    = 8'hFF;

    typedef enum logic [1:0] {
        DIG_ONES      = 2'd0,
        DIG_TENS      = 2'd1,
        DIG_HUNDREDS  = 2'd2,
        DIG_THOUSANDS = 2'd3
    } digit_t;

    logic [DIV_W-1:0] div_q, div_next;
    digit_t           digit_q, digit_next;
    logic [7:0]       value_q, value_next;
    logic             tick;

    logic [3:0] ones, tens, hund;
    logic       blank_tens, blank_hund;
    logic [3:0] com_next;
    logic [7:0] font_next;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    endfunction

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_next   = tick ? '0 : div_q + DIV_ONE;
        digit_next = digit_q;
        value_next = value_q;
        if (tick) begin
            case (digit_q)
                DIG_ONES:      digit_next = DIG_TENS;
                DIG_TENS:      digit_next = DIG_HUNDREDS;
                DIG_HUNDREDS:  digit_next = DIG_THOUSANDS;
                default: begin
                    digit_next = DIG_ONES;
                    value_next = i_value;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q   <= '0;
            digit_q <= DIG_ONES;
            value_q <= '0;
        end else begin
            div_q   <= div_next;
            digit_q <= digit_next;
            value_q <= value_next;
        end
    end

    always_comb begin
        ones = 4'(value_q % 8'd10);
        tens = 4'((value_q / 8'd10) % 8'd10);
        hund = 4'(value_q / 8'd100);
        blank_hund = BLANK_LZ && (hund == 4'd0);
        blank_tens = blank_hund && (tens == 4'd0);
    end

    // Outputs are registered from the current index/latch, so they trail each index change by one cycle.
    always_comb begin
        com_next  = 4'b1111;
        font_next = BLANK;
        case (digit_q)
            DIG_ONES: begin
                com_next  = 4'b1110;
                font_next = seg(ones);
            end
            DIG_TENS: begin
                com_next  = 4'b1101;
                font_next = blank_tens ? BLANK : seg(tens);
            end
            DIG_HUNDREDS: begin
                com_next  = 4'b1011;
                font_next = blank_hund ? BLANK : seg(hund);
            end
            default: begin
                com_next  = 4'b0111;
                font_next = BLANK_LZ ? BLANK : seg(4'd0);
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_font <= BLANK;
        end else begin
            o_fnd_com  <= com_next;
            o_fnd_font <= font_next;
        end
    end

endmodule

// File: tb/tb_fnd_display_driver.sv
// Directed bench for fnd_display_driver: two instances (blanking on/off) share stimulus;
// expected per-cycle (com, font) entries are queued per frame and popped on each falling edge.
module tb_fnd_display_driver;

    typedef struct {
        logic [3:0] com;
        logic [7:0] font_b;
        logic [7:0] font_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic [3:0] com_b, com_n;
    logic [7:0] font_b, font_n;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    fnd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_value(value),
        .o_fnd_com(com_b), .o_fnd_font(font_b)
    );

    fnd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_n (
        .i_clk(clk), .i_reset(rst), .i_value(value),
        .o_fnd_com(com_n), .o_fnd_font(font_n)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic push_n(input logic [3:0] c, input logic [7:0] fb, input logic [7:0] fn, input int n);
        exp_t e;
        e.com = c; e.font_b = fb; e.font_n = fn;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Decimal split by repeated subtraction, independent of the divide/modulo form in the design.
    task automatic push_frame(input int v);
        int h, t, o, r;
        logic [7:0] fb [4];
        logic [7:0] fn [4];
        logic [3:0] coms [4];
        h = 0; t = 0; r = v;
        while (r >= 100) begin r -= 100; h++; end
        while (r >= 10)  begin r -= 10;  t++; end
        o = r;
        coms[0] = 4'b1110; coms[1] = 4'b1101; coms[2] = 4'b1011; coms[3] = 4'b0111;
        fn[0] = font_tab[o]; fn[1] = font_tab[t]; fn[2] = font_tab[h]; fn[3] = 8'hC0;
        fb[0] = fn[0];
        fb[1] = (h == 0 && t == 0) ? 8'hFF : fn[1];
        fb[2] = (h == 0) ? 8'hFF : fn[2];
        fb[3] = 8'hFF;
        for (int d = 0; d < 4; d++) push_n(coms[d], fb[d], fn[d], 4);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                total = total + 1;
                $error("FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("com_blank", {4'h0, com_b}, {4'h0, e.com});
                chk("font_blank", font_b, e.font_b);
                chk("com_noblank", {4'h0, com_n}, {4'h0, e.com});
                chk("font_noblank", font_n, e.font_n);
            end
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_com_blank"}, {4'h0, com_b}, 8'h0F);
        chk({tag, "_font_blank"}, font_b, 8'hFF);
        chk({tag, "_com_noblank"}, {4'h0, com_n}, 8'h0F);
        chk({tag, "_font_noblank"}, font_n, 8'hFF);
    endtask

    initial begin
        rst   = 1'b1;
        value = 8'd99;
        push_n(4'b1111, 8'hFF, 8'hFF, 5);
        run(5);

        rst   = 1'b0;
        value = 8'd123;
        push_frame(0);
        run(16);

        push_frame(123);
        run(4);
        value = 8'd255;
        run(12);

        push_frame(255);
        value = 8'd5;
        run(16);

        push_frame(5);
        value = 8'd0;
        run(16);

        push_frame(0);
        value = 8'd100;
        run(16);

        push_frame(100);
        value = 8'd123;
        run(16);

        push_frame(123);
        run(9);
        rst = 1'b1;
        #1;
        chk_blank("reset_immediate");
        q.delete();
        @(negedge clk);
        chk_blank("reset_held");
        rst = 1'b0;

        push_frame(0);
        run(16);
        push_frame(123);
        run(16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
